fetch_skid_buffer: RTL and testbench

FETCH_SKID_BUFFER -- requirements
Module: fetch_skid_buffer

---
 rtl/fetch_skid_buffer.sv | 102 ++++++++++
 tb/tb_fetch_skid_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - 2-entry fetch-to-decode skid FIFO; optional counters under FETCH_SKID_BUFFER_STATS_EN
module fetch_skid_buffer #(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_pc_i,
  input  logic [31:0] in_inst_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_inst_o,
  input  logic        out_ready_i
`ifdef FETCH_SKID_BUFFER_STATS_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [31:0] pc_q   [2];
  logic [31:0] inst_q [2];
  logic        push;
  logic        pop;

  // Handshakes and head presentation depend only on registered state plus run/flush qualifiers
  always_comb begin
    in_ready_o  = (state != FULL);
    out_valid_o = (state != EMPTY) & start_i;
    push        = start_i & in_valid_i & in_ready_o & ~flush_i;
    pop         = start_i & out_valid_o & out_ready_i & ~flush_i;
    out_pc_o    = 32'h0;
    out_inst_o  = NOP_INST;
    if (state != EMPTY) begin
      out_pc_o   = pc_q[rd_ptr];
      out_inst_o = inst_q[rd_ptr];
    end
  end

  // Occupancy FSM, pointers and entry storage; flush realigns pointers so the next push is the head
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= EMPTY;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      pc_q[0]   <= 32'h0;
      pc_q[1]   <= 32'h0;
      inst_q[0] <= 32'h0;
      inst_q[1] <= 32'h0;
    end else if (flush_i) begin
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (start_i) begin
      if (push) begin
        pc_q[wr_ptr]   <= in_pc_i;
        inst_q[wr_ptr] <= in_inst_i;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case (state)
        EMPTY:   if (push) state <= ONE;
        ONE: begin
          if (push && !pop)      state <= FULL;
          else if (pop && !push) state <= EMPTY;
        end
        FULL:    if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef FETCH_SKID_BUFFER_STATS_EN
  // Saturating counts of back-pressured fetch cycles and of flushes that discarded live entries
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= 32'h0;
      flush_cnt_o <= 16'h0;
    end else begin
      if (start_i && in_valid_i && !in_ready_o && (stall_cnt_o != 32'hFFFF_FFFF))
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_i && (state != EMPTY) && (flush_cnt_o != 16'hFFFF))
        flush_cnt_o <= flush_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_skid_buffer.sv
// tb/tb_fetch_skid_buffer.sv - scoreboard bench for fetch_skid_buffer
module tb_fetch_skid_buffer;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        flush_i;
  logic        in_valid_i;
  logic [31:0] in_pc_i;
  logic [31:0] in_inst_i;
  logic        in_ready_o;
  logic        out_valid_o;
  logic [31:0] out_pc_o;
  logic [31:0] out_inst_o;
  logic        out_ready_i;
`ifdef FETCH_SKID_BUFFER_STATS_EN
  logic [31:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;
  int unsigned m_stall;
  int unsigned m_flush;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  fetch_skid_buffer #(.NOP_INST(NOP)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_pc_i     (in_pc_i),
    .in_inst_i   (in_inst_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_pc_o    (out_pc_o),
    .out_inst_o  (out_inst_o),
    .out_ready_i (out_ready_i)
`ifdef FETCH_SKID_BUFFER_STATS_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic st, input logic fl, input logic iv,
                      input logic [31:0] pc, input logic [31:0] inst, input logic ordy);
    @(negedge clk_i);
    start_i     = st;
    flush_i     = fl;
    in_valid_i  = iv;
    in_pc_i     = pc;
    in_inst_i   = inst;
    out_ready_i = ordy;
  endtask

  // Reference model: a FIFO of at most two entries, cleared by reset or flush
  initial begin : model
    forever begin
      @(negedge clk_i);
      #1;
      if (!rst_i) begin
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_pc", out_pc_o, 32'h0);
        chk("rst_out_inst", out_inst_o, NOP);
        exp_q.delete();
`ifdef FETCH_SKID_BUFFER_STATS_EN
        m_stall = 0;
        m_flush = 0;
`endif
      end else begin
        chk("in_ready", in_ready_o, exp_q.size() != 2);
        chk("out_valid", out_valid_o, (exp_q.size() != 0) && start_i);
        if (exp_q.size() == 0) begin
          chk("empty_pc", out_pc_o, 32'h0);
          chk("empty_inst", out_inst_o, NOP);
        end
`ifdef FETCH_SKID_BUFFER_STATS_EN
        chk("stall_cnt", stall_cnt_o, m_stall);
        chk("flush_cnt", {16'h0, flush_cnt_o}, m_flush);
        if (start_i && in_valid_i && exp_q.size() == 2) m_stall++;
        if (flush_i && exp_q.size() != 0) m_flush++;
`endif
        if (flush_i)
          exp_q.delete();
        else if (start_i && in_valid_i && exp_q.size() < 2)
          exp_q.push_back({in_pc_i, in_inst_i});
      end
    end
  end

  // Monitor: whenever a head is presented it must match the oldest expected entry
  initial begin : monitor
    forever begin
      @(negedge clk_i);
      #4;
      if (rst_i && out_valid_o && !flush_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL head_unexpected: got pc %h with no entry expected at %0t", out_pc_o, $time);
        end else begin
          chk("head_pc", out_pc_o, exp_q[0].pc);
          chk("head_inst", out_inst_o, exp_q[0].inst);
          if (out_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin : driver
    rst_i = 1'b0;
    start_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0;
    in_pc_i = 32'h0; in_inst_i = 32'h0; out_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #3;
    chk("reset_inst", out_inst_o, NOP);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Single push then drain
    step(1, 0, 1, 32'h0, 32'h00500093, 1);
    step(1, 0, 0, 32'h0, 32'h0, 1);
    #3;
    chk("d31_valid", out_valid_o, 1);
    chk("d31_pc", out_pc_o, 32'h0);
    chk("d31_inst", out_inst_o, 32'h00500093);
    step(1, 0, 0, 32'h0, 32'h0, 1);
    #3;
    chk("d31_empty_valid", out_valid_o, 0);
    chk("d31_empty_inst", out_inst_o, NOP);

    // Fill to FULL, third push refused, drain in order
    step(1, 0, 1, 32'h4, 32'h104, 0);
    step(1, 0, 1, 32'h8, 32'h108, 0);
    step(1, 0, 1, 32'hC, 32'h10C, 0);
    #3;
    chk("d32_full_ready", in_ready_o, 0);
    step(1, 0, 0, 32'h0, 32'h0, 1);
    #3;
    chk("d32_first", out_pc_o, 32'h4);
    step(1, 0, 0, 32'h0, 32'h0, 1);
    #3;
    chk("d32_second", out_pc_o, 32'h8);
    step(1, 0, 0, 32'h0, 32'h0, 0);
    #3;
    chk("d32_drained", out_valid_o, 0);

    // ONE with simultaneous push and pop
    step(1, 0, 1, 32'hC, 32'h10C, 0);
    step(1, 0, 1, 32'h10, 32'h110, 1);
    #3;
    chk("d33_head_before", out_pc_o, 32'hC);
    step(1, 0, 0, 32'h0, 32'h0, 0);
    #3;
    chk("d33_head_after", out_pc_o, 32'h10);
    chk("d33_ready", in_ready_o, 1);
    step(1, 0, 0, 32'h0, 32'h0, 1);

    // Flush while FULL with a competing push
    step(1, 0, 1, 32'h20, 32'h120, 0);
    step(1, 0, 1, 32'h24, 32'h124, 0);
    step(1, 1, 1, 32'h28, 32'h128, 1);
    #3;
    chk("d34_full", in_ready_o, 0);
    step(1, 0, 0, 32'h0, 32'h0, 0);
    #3;
    chk("d34_valid", out_valid_o, 0);
    chk("d34_ready", in_ready_o, 1);
    chk("d34_inst", out_inst_o, NOP);

    // Run enable low freezes the buffer
    step(1, 0, 1, 32'h30, 32'h130, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 32'h34 + 32'(i), 32'h134, 1);
      #3;
      chk("d35_suspended", out_valid_o, 0);
    end
    step(1, 0, 0, 32'h0, 32'h0, 0);
    #3;
    chk("d35_valid", out_valid_o, 1);
    chk("d35_head", out_pc_o, 32'h30);
    step(1, 0, 0, 32'h0, 32'h0, 1);

    // Asynchronous reset while FULL
    step(1, 0, 1, 32'h40, 32'h140, 0);
    step(1, 0, 1, 32'h44, 32'h144, 0);
    step(1, 0, 0, 32'h0, 32'h0, 0);
    #6;
    rst_i = 1'b0;
    #1;
    chk("d36_valid", out_valid_o, 0);
    chk("d36_ready", in_ready_o, 1);
    chk("d36_pc", out_pc_o, 32'h0);
    chk("d36_inst", out_inst_o, NOP);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;

    // Randomised traffic with occasional flush, suspend and reset
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 6, $urandom, $urandom, $urandom_range(0, 1) == 1);
      rst_i = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
